// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch aligner:
//   XLEN / ILEN     default address and instruction widths
//   align_state_e   aligner FSM states
//   is_compressed() true when a 16-bit parcel starts an RVC instruction
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LO = 2'd1,
      WAIT_HI = 2'd2
   } align_state_e;

   // A parcel whose two low bits are not 2'b11 is a complete 16-bit instruction.
   function automatic logic is_compressed(input logic [15:0] half);
      return (half[1:0] != 2'b11);
   endfunction

endpackage

// File: rtl/riscv_align_hbuf.sv
// ----------------------------------------------------------------------------
// riscv_align_hbuf
// Holds the upper 16-bit half of the most recently returned instruction word
// together with the word tag (address bits [XLEN-1:2]) it came from.
// Ports:
//   i_riscv_hbuf_clk     clock, rising edge
//   i_riscv_hbuf_rst     synchronous active-low reset (buffer invalid)
//   i_riscv_hbuf_inval   invalidate (wins over load)
//   i_riscv_hbuf_load    load half/tag this cycle
//   i_riscv_hbuf_half    upper half of the returned word
//   i_riscv_hbuf_tag     word tag of the returned word
//   i_riscv_hbuf_lookup  word tag of the current PC
//   o_riscv_hbuf_hit     buffer valid and tag matches lookup
//   o_riscv_hbuf_half    buffered half
// ----------------------------------------------------------------------------
module riscv_align_hbuf #(
   parameter int XLEN = 64
) (
   input  logic            i_riscv_hbuf_clk,
   input  logic            i_riscv_hbuf_rst,
   input  logic            i_riscv_hbuf_inval,
   input  logic            i_riscv_hbuf_load,
   input  logic [15:0]     i_riscv_hbuf_half,
   input  logic [XLEN-3:0] i_riscv_hbuf_tag,
   input  logic [XLEN-3:0] i_riscv_hbuf_lookup,
   output logic            o_riscv_hbuf_hit,
   output logic [15:0]     o_riscv_hbuf_half
);

   logic            valid_reg;
   logic [XLEN-3:0] tag_reg;
   logic [15:0]     half_reg;

   always_ff @(posedge i_riscv_hbuf_clk) begin
      if (!i_riscv_hbuf_rst) begin
         valid_reg <= 1'b0;
         tag_reg   <= '0;
         half_reg  <= '0;
      end else if (i_riscv_hbuf_inval) begin
         valid_reg <= 1'b0;
      end else if (i_riscv_hbuf_load) begin
         valid_reg <= 1'b1;
         tag_reg   <= i_riscv_hbuf_tag;
         half_reg  <= i_riscv_hbuf_half;
      end
   end

   // Full upper-bit compare so a wrapped address never aliases an old word.
   assign o_riscv_hbuf_hit  = valid_reg && (tag_reg == i_riscv_hbuf_lookup);
   assign o_riscv_hbuf_half = half_reg;

endmodule

// File: rtl/riscv_fetch_align.sv
// ----------------------------------------------------------------------------
// riscv_fetch_align
// Fetch-stage aligner: turns the current PC into word-aligned memory requests
// and assembles 16/32-bit RV64IMC instructions, including ones that straddle
// a word boundary, into a registered instruction for decode.
// Ports:
//   i_riscv_align_clk / _rst        clock, synchronous active-low reset
//   i_riscv_align_pc                current PC
//   i_riscv_align_flush             redirect; PC loads the target this edge
//   o_riscv_align_stallpc           hold PC (low only on capture or flush)
//   o_riscv_align_pcplus            pc+2 / pc+4 for the next-PC mux
//   o_riscv_align_imem_req/_addr    one-cycle request strobe, word address
//   i_riscv_align_imem_rvalid/_rdata read return
//   o_riscv_align_valid/_instr/_instpc/_compressed  instruction to decode
//   i_riscv_align_ready             decode accepts this cycle
// ----------------------------------------------------------------------------
module riscv_fetch_align #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int ILEN = riscv_pkg::ILEN
) (
   input  logic            i_riscv_align_clk,
   input  logic            i_riscv_align_rst,
   input  logic [XLEN-1:0] i_riscv_align_pc,
   input  logic            i_riscv_align_flush,
   output logic            o_riscv_align_stallpc,
   output logic [XLEN-1:0] o_riscv_align_pcplus,
   output logic            o_riscv_align_imem_req,
   output logic [XLEN-1:0] o_riscv_align_imem_addr,
   input  logic            i_riscv_align_imem_rvalid,
   input  logic [31:0]     i_riscv_align_imem_rdata,
   output logic            o_riscv_align_valid,
   output logic [ILEN-1:0] o_riscv_align_instr,
   output logic [XLEN-1:0] o_riscv_align_instpc,
   output logic            o_riscv_align_compressed,
   input  logic            i_riscv_align_ready
);

   import riscv_pkg::*;

   localparam logic [XLEN-1:0] STEP2 = XLEN'(2);
   localparam logic [XLEN-1:0] STEP4 = XLEN'(4);

   align_state_e    state_reg, state_next;
   logic            req_reg, req_next;
   logic [XLEN-1:0] addr_reg, addr_next;
   logic [15:0]     lo_reg, lo_next;
   logic            drop_reg, drop_next;
   // Assembled instruction parked while decode is back-pressuring.
   logic            hold_v_reg, hold_v_next;
   logic [ILEN-1:0] hold_instr_reg, hold_instr_next;
   logic            hold_comp_reg, hold_comp_next;
   logic            valid_reg;
   logic [ILEN-1:0] instr_reg;
   logic [XLEN-1:0] instpc_reg;
   logic            comp_reg;

   logic            cand_v, cand_comp, capture, buf_load, buf_inval, buf_hit;
   logic [ILEN-1:0] cand_instr;
   logic [15:0]     buf_half;

   wire [XLEN-1:0] pc      = i_riscv_align_pc;
   wire [XLEN-1:0] pc_word = {pc[XLEN-1:2], 2'b00};
   wire            can_cap = !valid_reg || i_riscv_align_ready;
   wire [15:0]     rd_half = pc[1] ? i_riscv_align_imem_rdata[31:16]
                                   : i_riscv_align_imem_rdata[15:0];
   // A return in the same cycle as its request is impossible, so it is stale.
   wire            rvalid_ok = i_riscv_align_imem_rvalid && !req_reg;
   wire            unused_pc0 = pc[0];

   riscv_align_hbuf #(.XLEN(XLEN)) u_hbuf (
      .i_riscv_hbuf_clk    (i_riscv_align_clk),
      .i_riscv_hbuf_rst    (i_riscv_align_rst),
      .i_riscv_hbuf_inval  (buf_inval),
      .i_riscv_hbuf_load   (buf_load),
      .i_riscv_hbuf_half   (i_riscv_align_imem_rdata[31:16]),
      .i_riscv_hbuf_tag    (addr_reg[XLEN-1:2]),
      .i_riscv_hbuf_lookup (pc[XLEN-1:2]),
      .o_riscv_hbuf_hit    (buf_hit),
      .o_riscv_hbuf_half   (buf_half)
   );

   always_comb begin
      state_next      = state_reg;
      req_next        = 1'b0;
      addr_next       = addr_reg;
      lo_next         = lo_reg;
      drop_next       = drop_reg;
      hold_v_next     = hold_v_reg;
      hold_instr_next = hold_instr_reg;
      hold_comp_next  = hold_comp_reg;
      cand_v          = 1'b0;
      cand_instr      = '0;
      cand_comp       = 1'b0;
      buf_load        = 1'b0;
      buf_inval       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (drop_reg && rvalid_ok)
               drop_next = 1'b0;
            if (pc[1] && buf_hit && is_compressed(buf_half)) begin
               cand_v     = 1'b1;
               cand_instr = ILEN'({16'h0000, buf_half});
               cand_comp  = 1'b1;
            end else if (!drop_reg) begin
               req_next = 1'b1;
               if (pc[1] && buf_hit) begin
                  // Low half already buffered: only the next word is needed.
                  addr_next  = pc_word + STEP4;
                  lo_next    = buf_half;
                  state_next = WAIT_HI;
               end else begin
                  addr_next  = pc_word;
                  state_next = WAIT_LO;
               end
            end
         end
         WAIT_LO: begin
            if (hold_v_reg) begin
               cand_v     = 1'b1;
               cand_instr = hold_instr_reg;
               cand_comp  = hold_comp_reg;
            end else if (rvalid_ok) begin
               buf_load = 1'b1;
               if (pc[1] && !is_compressed(rd_half)) begin
                  lo_next    = rd_half;
                  req_next   = 1'b1;
                  addr_next  = addr_reg + STEP4;
                  state_next = WAIT_HI;
               end else if (is_compressed(rd_half)) begin
                  cand_v     = 1'b1;
                  cand_instr = ILEN'({16'h0000, rd_half});
                  cand_comp  = 1'b1;
               end else begin
                  cand_v     = 1'b1;
                  cand_instr = ILEN'(i_riscv_align_imem_rdata);
               end
            end
         end
         WAIT_HI: begin
            if (hold_v_reg) begin
               cand_v     = 1'b1;
               cand_instr = hold_instr_reg;
               cand_comp  = hold_comp_reg;
            end else if (rvalid_ok) begin
               buf_load   = 1'b1;
               cand_v     = 1'b1;
               cand_instr = ILEN'({i_riscv_align_imem_rdata[15:0], lo_reg});
            end
         end
         default: state_next = IDLE;
      endcase

      capture = cand_v && can_cap && !i_riscv_align_flush;

      if (cand_v && !capture && (state_reg != IDLE)) begin
         hold_v_next     = 1'b1;
         hold_instr_next = cand_instr;
         hold_comp_next  = cand_comp;
      end
      if (capture) begin
         state_next  = IDLE;
         hold_v_next = 1'b0;
      end

      if (i_riscv_align_flush) begin
         state_next  = IDLE;
         req_next    = 1'b0;
         hold_v_next = 1'b0;
         buf_inval   = 1'b1;
         // A request is in flight while waiting without parked data, or while
         // an earlier drop is still pending; a return this cycle retires it.
         drop_next   = (((state_reg != IDLE) && !hold_v_reg) || drop_reg) && !rvalid_ok;
      end
   end

   always_ff @(posedge i_riscv_align_clk) begin
      if (!i_riscv_align_rst) begin
         state_reg      <= IDLE;
         req_reg        <= 1'b0;
         addr_reg       <= '0;
         lo_reg         <= '0;
         drop_reg       <= 1'b0;
         hold_v_reg     <= 1'b0;
         hold_instr_reg <= '0;
         hold_comp_reg  <= 1'b0;
         valid_reg      <= 1'b0;
         instr_reg      <= '0;
         instpc_reg     <= '0;
         comp_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         req_reg        <= req_next;
         addr_reg       <= addr_next;
         lo_reg         <= lo_next;
         drop_reg       <= drop_next;
         hold_v_reg     <= hold_v_next;
         hold_instr_reg <= hold_instr_next;
         hold_comp_reg  <= hold_comp_next;
         if (i_riscv_align_flush) begin
            valid_reg <= 1'b0;
         end else if (capture) begin
            valid_reg  <= 1'b1;
            instr_reg  <= cand_instr;
            instpc_reg <= pc;
            comp_reg   <= cand_comp;
         end else if (i_riscv_align_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign o_riscv_align_stallpc    = !i_riscv_align_rst || !(capture || i_riscv_align_flush);
   assign o_riscv_align_pcplus     = pc + ((capture && cand_comp) ? STEP2 : STEP4);
   assign o_riscv_align_imem_req   = req_reg;
   assign o_riscv_align_imem_addr  = addr_reg;
   assign o_riscv_align_valid      = valid_reg;
   assign o_riscv_align_instr      = instr_reg;
   assign o_riscv_align_instpc     = instpc_reg;
   assign o_riscv_align_compressed = comp_reg;

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Directed bench for riscv_fetch_align; the bench plays PC register and memory.
module tb_riscv_fetch_align;

   logic        clk;
   logic        rst;
   logic [63:0] pc;
   logic        flush;
   logic        stallpc;
   logic [63:0] pcplus;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        rvalid;
   logic [31:0] rdata;
   logic        valid;
   logic [31:0] instr;
   logic [63:0] instpc;
   logic        compressed;
   logic        ready;

   int tests_run = 0;
   int tests_failed = 0;
   int req_count;

   riscv_fetch_align dut (
      .i_riscv_align_clk        (clk),
      .i_riscv_align_rst        (rst),
      .i_riscv_align_pc         (pc),
      .i_riscv_align_flush      (flush),
      .o_riscv_align_stallpc    (stallpc),
      .o_riscv_align_pcplus     (pcplus),
      .o_riscv_align_imem_req   (imem_req),
      .o_riscv_align_imem_addr  (imem_addr),
      .i_riscv_align_imem_rvalid(rvalid),
      .i_riscv_align_imem_rdata (rdata),
      .o_riscv_align_valid      (valid),
      .o_riscv_align_instr      (instr),
      .o_riscv_align_instpc     (instpc),
      .o_riscv_align_compressed (compressed),
      .i_riscv_align_ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) req_count <= 0;
      else if (imem_req) req_count <= req_count + 1;
   end

   task automatic do_reset();
      rst = 1'b0; flush = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b1; pc = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Waits (bounded) for a request strobe; drops rvalid on every cycle it waits.
   task automatic wait_req(output bit found, output logic [63:0] a);
      found = 1'b0; a = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rvalid = 1'b0;
         #1;
         if (imem_req === 1'b1) begin
            found = 1'b1; a = imem_addr;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b1; pc = '0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if ({valid, compressed, imem_req, stallpc} !== 4'b0001) begin
         tests_failed++; $display("FAIL reset_ctrl got v/c/req/stall=%b need 0001", {valid, compressed, imem_req, stallpc});
      end
      tests_run++;
      if (instr !== 32'h0 || instpc !== 64'h0 || imem_addr !== 64'h0) begin
         tests_failed++; $display("FAIL reset_data got instr=%h pc=%h addr=%h need zeros", instr, instpc, imem_addr);
      end
      $display("[TB] reset: valid=%b stallpc=%b", valid, stallpc);
      rst = 1'b1;
   endtask

   task automatic test_word32();
      bit f; logic [63:0] a;
      do_reset();
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h0) begin tests_failed++; $display("FAIL w32_req got found=%b addr=%h need 1/0", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00A00093; #1;
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'h4) begin
         tests_failed++; $display("FAIL w32_cap got stall=%b pcplus=%h need 0/4", stallpc, pcplus);
      end
      @(negedge clk); rvalid = 1'b0; pc = 64'h4; #1;
      tests_run++;
      if (valid !== 1'b1 || instr !== 32'h00A00093 || instpc !== 64'h0 || compressed !== 1'b0) begin
         tests_failed++; $display("FAIL w32_out got v=%b instr=%h pc=%h c=%b need 1/00a00093/0/0", valid, instr, instpc, compressed);
      end
      tests_run++;
      if (req_count !== 1) begin tests_failed++; $display("FAIL w32_reqcnt got %0d need 1", req_count); end
      $display("[TB] word32: instr=%h instpc=%h", instr, instpc);
   endtask

   task automatic test_compressed_hit();
      bit f; logic [63:0] a;
      do_reset();
      wait_req(f, a);
      @(negedge clk); rvalid = 1'b1; rdata = 32'h40514501; #1;
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'h2) begin
         tests_failed++; $display("FAIL c_cap got stall=%b pcplus=%h need 0/2", stallpc, pcplus);
      end
      @(negedge clk); rvalid = 1'b0; pc = 64'h2; #1;
      tests_run++;
      if (instr !== 32'h00004501 || compressed !== 1'b1) begin
         tests_failed++; $display("FAIL c_lo got instr=%h c=%b need 00004501/1", instr, compressed);
      end
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'h4) begin
         tests_failed++; $display("FAIL c_hit_cap got stall=%b pcplus=%h need 0/4", stallpc, pcplus);
      end
      @(negedge clk); pc = 64'h4; #1;
      tests_run++;
      if (instr !== 32'h00004051 || instpc !== 64'h2 || compressed !== 1'b1 || valid !== 1'b1) begin
         tests_failed++; $display("FAIL c_hi got instr=%h pc=%h c=%b v=%b need 00004051/2/1/1", instr, instpc, compressed, valid);
      end
      tests_run++;
      if (req_count !== 1) begin tests_failed++; $display("FAIL c_hit_noreq got %0d reqs need 1", req_count); end
      $display("[TB] compressed_hit: instr=%h instpc=%h", instr, instpc);
   endtask

   task automatic test_straddle();
      bit f; logic [63:0] a;
      do_reset();
      pc = 64'h6;
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h4) begin tests_failed++; $display("FAIL st_req1 got found=%b addr=%h need 1/4", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00931234; #1;
      tests_run++;
      if (stallpc !== 1'b1) begin tests_failed++; $display("FAIL st_lo_stall got %b need 1", stallpc); end
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h8) begin tests_failed++; $display("FAIL st_req2 got found=%b addr=%h need 1/8", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'hBEEF00A0; #1;
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'hA) begin
         tests_failed++; $display("FAIL st_cap got stall=%b pcplus=%h need 0/a", stallpc, pcplus);
      end
      @(negedge clk); rvalid = 1'b0; pc = 64'hA; #1;
      tests_run++;
      if (instr !== 32'h00A00093 || instpc !== 64'h6 || compressed !== 1'b0 || req_count !== 2) begin
         tests_failed++; $display("FAIL st_out got instr=%h pc=%h c=%b reqs=%0d need 00a00093/6/0/2", instr, instpc, compressed, req_count);
      end
      $display("[TB] straddle: instr=%h instpc=%h", instr, instpc);
   endtask

   task automatic test_backpressure();
      bit f; logic [63:0] a;
      do_reset();
      ready = 1'b0;
      wait_req(f, a);
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00A00093; #1;
      tests_run++;
      if (stallpc !== 1'b0) begin tests_failed++; $display("FAIL bp_first got stall=%b need 0", stallpc); end
      @(negedge clk); rvalid = 1'b0; pc = 64'h4;
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h4) begin tests_failed++; $display("FAIL bp_req got found=%b addr=%h need 1/4", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00B00113; #1;
      tests_run++;
      if (stallpc !== 1'b1) begin tests_failed++; $display("FAIL bp_stall got %b need 1", stallpc); end
      @(negedge clk); rvalid = 1'b0; #1;
      tests_run++;
      if (instr !== 32'h00A00093 || valid !== 1'b1 || stallpc !== 1'b1 || imem_req !== 1'b0) begin
         tests_failed++; $display("FAIL bp_hold got instr=%h v=%b stall=%b req=%b need 00a00093/1/1/0", instr, valid, stallpc, imem_req);
      end
      @(negedge clk); ready = 1'b1; #1;
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'h8) begin
         tests_failed++; $display("FAIL bp_release got stall=%b pcplus=%h need 0/8", stallpc, pcplus);
      end
      @(negedge clk); pc = 64'h8; #1;
      tests_run++;
      if (instr !== 32'h00B00113 || instpc !== 64'h4 || valid !== 1'b1) begin
         tests_failed++; $display("FAIL bp_out got instr=%h pc=%h v=%b need 00b00113/4/1", instr, instpc, valid);
      end
      $display("[TB] backpressure: instr=%h instpc=%h", instr, instpc);
   endtask

   task automatic test_flush();
      bit f; logic [63:0] a;
      do_reset();
      wait_req(f, a);
      @(negedge clk); flush = 1'b1; #1;
      tests_run++;
      if (stallpc !== 1'b0) begin tests_failed++; $display("FAIL fl_stall got %b need 0", stallpc); end
      @(negedge clk); flush = 1'b0; pc = 64'h100; #1;
      tests_run++;
      if (imem_req !== 1'b0 || valid !== 1'b0) begin
         tests_failed++; $display("FAIL fl_quiet got req=%b v=%b need 0/0", imem_req, valid);
      end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00A00093; #1;
      tests_run++;
      if (stallpc !== 1'b1 || imem_req !== 1'b0) begin
         tests_failed++; $display("FAIL fl_drop got stall=%b req=%b need 1/0", stallpc, imem_req);
      end
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h100 || valid !== 1'b0) begin
         tests_failed++; $display("FAIL fl_req got found=%b addr=%h v=%b need 1/100/0", f, a, valid);
      end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h00C00193; #1;
      @(negedge clk); rvalid = 1'b0; pc = 64'h104; #1;
      tests_run++;
      if (instr !== 32'h00C00193 || instpc !== 64'h100 || valid !== 1'b1) begin
         tests_failed++; $display("FAIL fl_out got instr=%h pc=%h v=%b need 00c00193/100/1", instr, instpc, valid);
      end
      $display("[TB] flush: instr=%h instpc=%h", instr, instpc);
   endtask

   task automatic test_wrap();
      bit f; logic [63:0] a;
      do_reset();
      pc = 64'hFFFF_FFFF_FFFF_FFFE;
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'hFFFF_FFFF_FFFF_FFFC) begin tests_failed++; $display("FAIL wr_req1 got found=%b addr=%h need 1/fffffffffffffffc", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'h01131111; #1;
      wait_req(f, a);
      tests_run++;
      if (!f || a !== 64'h0) begin tests_failed++; $display("FAIL wr_req2 got found=%b addr=%h need 1/0", f, a); end
      @(negedge clk); rvalid = 1'b1; rdata = 32'hAAAA0050; #1;
      tests_run++;
      if (stallpc !== 1'b0 || pcplus !== 64'h2) begin
         tests_failed++; $display("FAIL wr_cap got stall=%b pcplus=%h need 0/2", stallpc, pcplus);
      end
      @(negedge clk); rvalid = 1'b0; pc = 64'h2; #1;
      tests_run++;
      if (instr !== 32'h00500113 || instpc !== 64'hFFFF_FFFF_FFFF_FFFE || compressed !== 1'b0) begin
         tests_failed++; $display("FAIL wr_out got instr=%h pc=%h c=%b need 00500113/fffffffffffffffe/0", instr, instpc, compressed);
      end
      $display("[TB] wrap: instr=%h instpc=%h", instr, instpc);
   endtask

   initial begin
      test_reset();
      test_word32();
      test_compressed_hit();
      test_straddle();
      test_backpressure();
      test_flush();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/riscv_fetch_align.md
Name: riscv_fetch_align

Overview:
Fetch-stage aligner sitting directly downstream of the PC register, which is reset to 0x0. It takes the current PC and issues word-aligned requests to instruction memory. A 16-bit upper-half buffer lets it assemble RV64IMC instructions that are 16-bit or 32-bit and may straddle a word boundary. It drives the PC register's stall input, supplies the sequential PC increment to the next-PC mux, and hands a registered instruction to decode.

Parameters:
XLEN, 64, PC/address width
ILEN, 32, instruction width

Ports:
i_riscv_align_clk  in  1  clock, rising edge
i_riscv_align_rst  in  1  synchronous, active-low reset
i_riscv_align_pc  in  XLEN  current PC from PC register
i_riscv_align_flush  in  1  redirect (branch/trap); PC register loads the target the same edge
o_riscv_align_stallpc  out  1  to PC register: hold PC
o_riscv_align_pcplus  out  XLEN  pc+2 (compressed) or pc+4, for the next-PC mux
o_riscv_align_imem_req  out  1  memory request strobe, 1 cycle
o_riscv_align_imem_addr  out  XLEN  word-aligned address, bits[1:0]=0
i_riscv_align_imem_rvalid  in  1  read data valid
i_riscv_align_imem_rdata  in  32  read word
o_riscv_align_valid  out  1  instruction valid to decode
o_riscv_align_instr  out  ILEN  instruction; upper 16 bits zero when compressed
o_riscv_align_instpc  out  XLEN  PC of o_riscv_align_instr
o_riscv_align_compressed  out  1  instr[1:0] != 2'b11
i_riscv_align_ready  in  1  decode accepts this cycle

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE; buffer invalid; drop flag cleared. Outputs: valid=0, instr=0, instpc=0, compressed=0, imem_req=0, imem_addr=0, stallpc=1.
- Memory protocol: at most one outstanding request. rvalid arrives ≥1 cycle after req. The address is held stable until rvalid.
- Buffer: 16-bit half plus word tag. Loaded with rdata[31:16] and tag = addr[XLEN-1:2] on every word return.
- FSM states: IDLE, WAIT_LO, WAIT_HI.
- IDLE, pc[1]=1, buffer hit (tag == pc[XLEN-1:2]):
  - Half compressed: capture with no memory access.
  - Half is 32-bit low half: req addr = (pc & ~3)+4, go to WAIT_HI.
- IDLE, otherwise: req addr = pc & ~3, go to WAIT_LO.
- WAIT_LO on rvalid, selected half h = pc[1] ? rdata[31:16] : rdata[15:0]:
  - pc[1]=0 and h is compressed: capture h.
  - pc[1]=0 and 32-bit: capture rdata.
  - pc[1]=1 and h is compressed: capture h.
  - pc[1]=1 and 32-bit: hold h, req addr+4, go to WAIT_HI.
- WAIT_HI on rvalid: capture {rdata[15:0], low half}.
- Capture:
  - Allowed only when (!valid || ready); otherwise stay in the current state holding the assembled instruction.
  - On capture, register instr/instpc=pc/compressed, set valid=1, and deassert stallpc for exactly that cycle. The PC advances on the next edge; return to IDLE.
- valid clears when ready=1 and there is no new capture.
- stallpc=1 in every non-capture cycle.
- pcplus is combinational: pc + (compressed-of-instruction-being-captured ? 2 : 4). It is meaningful only when stallpc=0.
- Flush (highest priority, any state):
  - Next edge: valid=0, buffer invalid, state=IDLE, stallpc=0 in the flush cycle.
  - If a request is outstanding, set the drop flag; the next rvalid is discarded and the drop flag clears.
  - No new request issues while the drop flag is set.
- Flush and capture in the same cycle: flush wins and nothing is captured.
- Flush and rvalid in the same cycle: the data is discarded and the drop flag is not set.
- Wrap-around: addr+4 wraps modulo 2^XLEN; the buffer tag compares full upper bits.
- Reset mid-request: any later rvalid is ignored until the first req after reset.

Decomposition:
- Shared package riscv_pkg: align_state_e enum (IDLE, WAIT_LO, WAIT_HI), function is_compressed(16-bit), XLEN/ILEN constants.
- One natural sub-module: riscv_align_hbuf, the half-word buffer with tag, hit compare and invalidate.

Test Plan:
- Reset then pc=0x0, rdata=0x00A00093 after 1 cycle -> instr=0x00A00093, compressed=0, instpc=0, pcplus=0x4, exactly one req at addr 0x0.
- pc=0x0, rdata=0x40514501 -> capture instr=0x00004501, compressed=1. Then pc=0x2 -> instr=0x00004051 with no new req (buffer hit), pcplus=0x4.
- pc=0x6, word@0x4=0x0093xxxx with bits[17:16]=11, word@0x8=0xxxxx00A0 -> two reqs (0x4, 0x8), instr=0x00A00093, instpc=0x6, pcplus=0xA.
- ready=0 while valid=1 and next word returns -> stallpc stays 1, instr unchanged, captured only the cycle after ready=1.
- Flush asserted in WAIT_LO before rvalid, PC reloaded to 0x100 -> stale rvalid dropped, next req addr=0x100, valid never asserts with the old data.
- pc=0xFFFF_FFFF_FFFF_FFFE with a 32-bit low half -> second req addr=0x0, instr assembled correctly.
